// File: rtl/byte_to_bcd.sv
// byte_to_bcd: sequential double-dabble binary-to-BCD converter with a one-deep pending buffer.
// Define BCD_BLANK_EN to add registered leading-zero blank flags blank1_o/blank2_o.
module byte_to_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             busy_o,
  output logic             out_valid_o,
  output logic [3:0]       bcd0_o,
  output logic [3:0]       bcd1_o,
  output logic [3:0]       bcd2_o,
`ifdef BCD_BLANK_EN
  output logic             blank1_o,
  output logic             blank2_o,
`endif
  output logic             overrun_o
);
  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       acc_q, acc_d, adj;
  logic [WIDTH-1:0]    bin_q, bin_d, pend_q, pend_d, nxt;
  logic                pend_v_q, pend_v_d, ovr_q, ovr_d, ov_q, ov_d;
  logic [11:0]         bcd_q, bcd_d;
  logic [AW+WIDTH-1:0] sh;
  logic                done_go;
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = acc_q[4*i+:4] >= 4'd5 ? acc_q[4*i+:4] + 4'd3 : acc_q[4*i+:4];
  end
  assign sh      = {adj, bin_q} << 1;
  assign done_go = state_q == S_SHIFT && cnt_q == CW'(WIDTH);
  assign nxt     = pend_v_q ? pend_q : in_data_i;
  // A load from DONE applies the first (correction-free) shift immediately so back-to-back results are WIDTH+1 apart.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    bin_d    = bin_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ovr_d    = ovr_q;
    bcd_d    = bcd_q;
    ov_d     = 1'b0;
    if (state_q == S_IDLE) begin
      if (in_valid_i) begin
        bin_d   = in_data_i;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
    end else if (state_q == S_SHIFT) begin
      if (done_go) begin
        state_d = S_DONE;
        bcd_d   = acc_q[11:0];
        ov_d    = 1'b1;
      end else begin
        acc_d = sh[AW+WIDTH-1:WIDTH];
        bin_d = sh[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
      end
      if (in_valid_i) begin
        pend_d   = in_data_i;
        pend_v_d = 1'b1;
        ovr_d    = ovr_q | pend_v_q;
      end
    end else begin
      if (pend_v_q || in_valid_i) begin
        acc_d   = AW'(nxt[WIDTH-1]);
        bin_d   = nxt << 1;
        cnt_d   = CW'(1);
        state_d = S_SHIFT;
      end else begin
        state_d = S_IDLE;
      end
      if (pend_v_q) begin
        pend_v_d = in_valid_i;
        pend_d   = in_valid_i ? in_data_i : pend_q;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      bin_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ovr_q    <= 1'b0;
      ov_q     <= 1'b0;
      bcd_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      bin_q    <= bin_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ovr_q    <= ovr_d;
      ov_q     <= ov_d;
      bcd_q    <= bcd_d;
    end
  end
  assign busy_o      = state_q != S_IDLE;
  assign out_valid_o = ov_q;
  assign overrun_o   = ovr_q;
  assign bcd0_o      = bcd_q[3:0];
  assign bcd1_o      = bcd_q[7:4];
  assign bcd2_o      = bcd_q[11:8];
`ifdef BCD_BLANK_EN
  logic blank1_q, blank1_d, blank2_q, blank2_d;
  always_comb begin
    blank2_d = done_go ? acc_q[11:8] == 4'd0 : blank2_q;
    blank1_d = done_go ? acc_q[11:4] == 8'd0 : blank1_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blank1_q <= 1'b1;
      blank2_q <= 1'b1;
    end else begin
      blank1_q <= blank1_d;
      blank2_q <= blank2_d;
    end
  end
  assign blank1_o = blank1_q;
  assign blank2_o = blank2_q;
`endif
endmodule

// File: doc/byte_to_bcd.md
# byte_to_bcd

Sequential binary-to-BCD converter, double-dabble, that sits between the SPI slave receive path and the seven-segment decoders. It accepts each received byte with a one-cycle valid strobe and converts it over WIDTH clocks using shift-and-add-3. It presents three registered BCD digits, units, tens and hundreds, that hold until the next conversion completes. A one-deep pending buffer absorbs a byte arriving mid-conversion. An overrun flag reports bytes that were lost.

## Interface
- WIDTH, 8: binary input width; shift iterations per conversion.
- DIGITS, 3: BCD digits produced; must cover 2^WIDTH-1 (3 for WIDTH=8).
- clock  in  1  system clock; all state on its rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- in_data  in  WIDTH  received binary value.
- in_valid  in  1  one-cycle strobe; in_data is valid while high.
- busy  out  1  conversion in progress (SHIFT or DONE state).
- out_valid  out  1  one-cycle pulse; bcd0..bcd2 updated this cycle.
- bcd0  out  4  units digit.
- bcd1  out  4  tens digit.
- bcd2  out  4  hundreds digit.
- overrun  out  1  sticky: a pending byte was overwritten before use.

## Operation
- Reset: state IDLE; all of the following are 0: bcd0, bcd1, bcd2, out_valid, busy, overrun, the pending-valid flag, the iteration counter, and the shift register.
- FSM states:
  - IDLE: on in_valid, load in_data into the binary shift register, clear the BCD accumulator and the counter, then go to SHIFT.
  - SHIFT: one iteration per cycle. For each accumulator nibble, if the nibble is ≥5, add 3. Then shift {accumulator, binary} left by 1. Increment the counter. After iteration WIDTH, go to DONE.
  - DONE: register the accumulator into bcd0..bcd2, pulse out_valid, then select the next state:
    - pending-valid set: load the pending byte, clear pending-valid, go to SHIFT.
    - else in_valid high: load in_data, go to SHIFT.
    - else: go to IDLE.
- in_valid during SHIFT:
  - Pending empty: write the byte to the pending register and set pending-valid.
  - Pending full: overwrite the pending register with the newest byte and set overrun.
- in_valid during DONE with pending full: the pending byte starts converting, the new byte enters pending, and overrun is not set.
- Accumulator width is 4·DIGITS. The add-3 correction is done per nibble and never carries between nibbles. Input is unsigned; no saturation is needed.
- overrun clears only on reset.
- Reset asserted mid-conversion: everything returns to the reset values on that edge. The partial result and the pending byte are discarded, and out_valid does not pulse.

## Timing
- in_valid sampled in IDLE at edge E0.
- SHIFT iterations occupy the cycles after edges E0+1 through E0+WIDTH.
- DONE state, with out_valid high and new digits visible, is the cycle after edge E0+WIDTH+1. Latency is WIDTH+1 clocks (9 for WIDTH=8).
- busy is high from the cycle after E0 through the DONE cycle inclusive. busy is low in IDLE.
- Back-to-back throughput: one result per WIDTH+1 clocks. No idle cycle is inserted between DONE and the next SHIFT.
- bcd0..bcd2 change only in the DONE cycle. They are stable at all other times, which makes them safe to drive the seven-segment decoders directly.

## Configuration
- BCD_BLANK_EN defined:
  - Adds outputs blank1 and blank2, 1 bit each, registered together with the digits in DONE.
  - blank2 = (bcd2==0).
  - blank1 = blank2 && (bcd1==0).
  - Both reset to 1.
  - The display wrapper forces blanked digits off, so leading zeros are suppressed; bcd0 is never blanked.
- BCD_BLANK_EN undefined: the ports are absent and all three digits always display, including leading zeros.

## Test plan
- Reset, then in_valid with in_data=255 → out_valid exactly 9 clocks later with bcd2=2, bcd1=5, bcd0=5; busy high for those 9 cycles.
- in_data=0, then 10, then 99 (each sent after the previous out_valid) → 0/0/0, 0/1/0, 0/9/9 (bcd2/bcd1/bcd0). With BCD_BLANK_EN, 10 gives blank2=1, blank1=0, and 0 gives blank2=1, blank1=1.
- 128 sent; 37 sent 3 clocks later → 1/2/8, then 0/3/7 at out_valid 9 clocks after the first; overrun stays 0.
- 128 sent; 37 at +3; 200 at +5 → results 1/2/8 then 2/0/0; 37 is lost; overrun=1 and stays 1 until reset.
- 77 sent; reset asserted at +4 for one clock → no out_valid, bcd all 0, busy 0. Next 64 sent → 0/6/4 after 9 clocks.
- Exhaustive sweep of 0..255 at full rate (in_valid in each DONE cycle) → every result matches the decimal digits; out_valid spacing is exactly 9 clocks.
